// File: rtl/relay_sched_if.sv
// relay_sched_if: ARM-side strobes and relay-block outputs of the relay
// session sequencer, bundled so the sequencer and its driver share one port.
//   enable    ARM session enable (low aborts a session)
//   start     request to begin a session
//   ssp_dout  ARM transmit data (high = ARM activity)
//   data_in   line from the peer Proxmark (high = peer activity)
//   mod_type  3-bit mode select to the relay block
//   busy      sequencer is in a session
//   timeout   last session ended waiting for ARM or peer
//   state     debug state encoding
interface relay_sched_if;
  logic       enable;
  logic       start;
  logic       ssp_dout;
  logic       data_in;
  logic [2:0] mod_type;
  logic       busy;
  logic       timeout;
  logic [2:0] state;

  // master: the ARM / stimulus side
  modport master (
    output enable, start, ssp_dout, data_in,
    input  mod_type, busy, timeout, state
  );

  // slave: the sequencer
  modport slave (
    input  enable, start, ssp_dout, data_in,
    output mod_type, busy, timeout, state
  );
endinterface

// File: rtl/relay_sched.sv
// relay_sched: runs one relay exchange without ARM intervention.
// FWD forwards the ARM frame (MASTER), WAIT waits for the peer answer,
// RET returns it to the ARM (SLAVE), REPORT holds DELAY mode while the
// measured delay is shifted out. Inputs are sampled once every 8 clocks.
// Ports:
//   ck_1356meg  13.56 MHz clock
//   reset       synchronous active-high reset
//   bus         relay_sched_if.slave (enable/start/ssp_dout/data_in in,
//               mod_type/busy/timeout/state out)
module relay_sched #(
  parameter int unsigned RESP_TIMEOUT = 4096,
  parameter int unsigned QUIET_TICKS  = 64,
  parameter int unsigned DELAY_HOLD   = 65552
) (
  input  logic          ck_1356meg,
  input  logic          reset,
  relay_sched_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FWD    = 3'd1,
    S_WAIT   = 3'd2,
    S_RET    = 3'd3,
    S_REPORT = 3'd4
  } state_e;

  localparam logic [16:0] RT = 17'(RESP_TIMEOUT);
  localparam logic [16:0] QT = 17'(QUIET_TICKS);
  localparam logic [16:0] DH = 17'(DELAY_HOLD);

  state_e      state_q, state_d;
  logic [2:0]  presc_q;
  logic [16:0] cnt_q, cnt_d, cnt_inc;
  logic        seen_q, seen_d;
  logic        timeout_q, timeout_d;
  logic [2:0]  mod_q, mod_d;
  logic        busy_q;
  logic        tick;

  assign tick    = (presc_q == 3'd7);
  assign cnt_inc = cnt_q + 17'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    seen_d    = seen_q;
    timeout_d = timeout_q;
    // Abort wins over anything tick-driven and leaves timeout alone.
    if (state_q != S_IDLE && !bus.enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (bus.start && bus.enable) begin
          state_d   = S_FWD;
          timeout_d = 1'b0;
          seen_d    = 1'b0;
        end
        S_FWD: if (tick) begin
          if (bus.ssp_dout) begin
            seen_d = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_inc;
            // Once the ARM has spoken, cnt measures quiet time;
            // before that it measures the wait for the ARM.
            if (seen_q && cnt_inc == QT) state_d = S_WAIT;
            else if (!seen_q && cnt_inc == RT) begin
              state_d   = S_IDLE;
              timeout_d = 1'b1;
            end
          end
        end
        S_WAIT: if (tick) begin
          if (bus.data_in) state_d = S_RET;
          else begin
            cnt_d = cnt_inc;
            if (cnt_inc == RT) begin
              state_d   = S_IDLE;
              timeout_d = 1'b1;
            end
          end
        end
        S_RET: if (tick) begin
          if (bus.data_in) cnt_d = '0;
          else begin
            cnt_d = cnt_inc;
            if (cnt_inc == QT) state_d = S_REPORT;
          end
        end
        S_REPORT: if (tick) begin
          cnt_d = cnt_inc;
          if (cnt_inc == DH) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs decode the next state so they move on the same edge as state.
  always_comb begin
    case (state_d)
      S_RET:    mod_d = 3'b001;
      S_REPORT: mod_d = 3'b010;
      default:  mod_d = 3'b000;
    endcase
  end

  always_ff @(posedge ck_1356meg) begin
    if (reset) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      cnt_q     <= '0;
      seen_q    <= 1'b0;
      timeout_q <= 1'b0;
      mod_q     <= 3'b000;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_q + 3'd1;
      cnt_q     <= cnt_d;
      seen_q    <= seen_d;
      timeout_q <= timeout_d;
      mod_q     <= mod_d;
      busy_q    <= (state_d != S_IDLE);
    end
  end

  assign bus.mod_type = mod_q;
  assign bus.busy     = busy_q;
  assign bus.timeout  = timeout_q;
  assign bus.state    = state_q;

endmodule
